// File: rtl/ddr3_command_responder.sv
// DDR3 device stand-in for the memory controller: decodes command pins at ck rate,
// tracks open banks, stores write bursts in a small RAM and replays them on reads.
module ddr3_command_responder #(
  parameter int DQ_BITWIDTH           = 16,
  parameter int DM_BITWIDTH           = DQ_BITWIDTH / 8,
  parameter int ADDRESS_BITWIDTH      = 14,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int CWL                   = 5,
  parameter int DEFAULT_CL            = 5,
  localparam int NUM_BANKS            = 2 ** BANK_ADDRESS_BITWIDTH
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             clk_slow_posedge,
  input  logic                             clk180_slow_posedge,
  input  logic                             reset_n,
  input  logic                             ck_en,
  input  logic                             cs_n,
  input  logic                             ras_n,
  input  logic                             cas_n,
  input  logic                             we_n,
  input  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address,
  input  logic [ADDRESS_BITWIDTH-1:0]      address,
  input  logic [DQ_BITWIDTH-1:0]           dq_in,
  input  logic [DM_BITWIDTH-1:0]           dm,
  output logic [DQ_BITWIDTH-1:0]           dq_out,
  output logic                             dq_oe,
  output logic                             read_beat_valid,
  output logic [NUM_BANKS-1:0]             open_bank_mask,
  output logic [15:0]                      refresh_count,
  output logic                             protocol_error
);

  localparam int RAM_AW = BANK_ADDRESS_BITWIDTH + 5;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LAT, S_BURST} state_e;

  state_e                           state;
  logic [3:0]                       cl;
  logic [3:0]                       lat_cnt;
  logic [2:0]                       beat;
  logic [BANK_ADDRESS_BITWIDTH-1:0] burst_bank;
  logic [1:0]                       burst_col;
  logic                             burst_read;

  logic [DQ_BITWIDTH-1:0] mem [2**RAM_AW];

  logic              cmd_valid;
  cmd_e              cmd;
  logic              bank_open;
  logic              beat_fire;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_bits;

  assign cmd_valid = clk_slow_posedge & ck_en & ~cs_n;
  assign cmd       = cmd_e'({ras_n, cas_n, we_n});
  assign bank_open = open_bank_mask[bank_address];
  assign ram_idx   = {burst_bank, burst_col, beat};
  assign unused_addr_bits = ^{address[ADDRESS_BITWIDTH-1:11], address[9:7], address[2:0]};

  // Beat 0 lands on the ck rising edge where the latency count expires; later
  // beats alternate falling/rising strobes, odd beats on the falling edge.
  assign beat_fire = reset_n &
                     (((state == S_WAIT_LAT) & clk_slow_posedge & (lat_cnt == 4'd1)) |
                      ((state == S_BURST) & (beat[0] ? clk180_slow_posedge : clk_slow_posedge)));

  // NOTE: the RAM has no reset; its contents must survive both resets, and
  // leaving it out of the reset domain lets it map onto plain RAM primitives.
  always_ff @(posedge clk) begin
    if (beat_fire && !burst_read) begin
      for (int i = 0; i < DM_BITWIDTH; i++) begin
        if (!dm[i]) mem[ram_idx][i*8 +: 8] <= dq_in[i*8 +: 8];
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      cl              <= 4'(DEFAULT_CL);
      lat_cnt         <= '0;
      beat            <= '0;
      burst_bank      <= '0;
      burst_col       <= '0;
      burst_read      <= 1'b0;
      dq_out          <= '0;
      dq_oe           <= 1'b0;
      read_beat_valid <= 1'b0;
      open_bank_mask  <= '0;
      refresh_count   <= '0;
      protocol_error  <= 1'b0;
    end else if (!reset_n) begin
      state           <= S_IDLE;
      cl              <= 4'(DEFAULT_CL);
      lat_cnt         <= '0;
      beat            <= '0;
      burst_bank      <= '0;
      burst_col       <= '0;
      burst_read      <= 1'b0;
      dq_out          <= '0;
      dq_oe           <= 1'b0;
      read_beat_valid <= 1'b0;
      open_bank_mask  <= '0;
      refresh_count   <= '0;
      protocol_error  <= 1'b0;
    end else begin
      read_beat_valid <= 1'b0;

      if (cmd_valid) begin
        case (cmd)
          CMD_ACT: begin
            if (bank_open) protocol_error <= 1'b1;
            else open_bank_mask[bank_address] <= 1'b1;
          end
          CMD_PRE: begin
            if (address[10]) open_bank_mask <= '0;
            else open_bank_mask[bank_address] <= 1'b0;
          end
          CMD_REF: begin
            refresh_count <= refresh_count + 16'd1;
            if (|open_bank_mask) protocol_error <= 1'b1;
          end
          CMD_MRS: begin
            if (bank_address == '0) cl <= {1'b0, address[6:4]} + 4'd4;
          end
          CMD_RD, CMD_WR: begin
            if (!bank_open || state != S_IDLE) begin
              protocol_error <= 1'b1;
            end else begin
              state      <= S_WAIT_LAT;
              lat_cnt    <= (cmd == CMD_RD) ? cl : 4'(CWL);
              burst_bank <= bank_address;
              burst_col  <= address[4:3];
              burst_read <= (cmd == CMD_RD);
              beat       <= '0;
            end
          end
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          // Read data stays driven until the ck rising edge after beat 7.
          if (dq_oe && clk_slow_posedge) dq_oe <= 1'b0;
        end
        S_WAIT_LAT: begin
          if (clk_slow_posedge) begin
            if (lat_cnt == 4'd1) state <= S_BURST;
            else lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_BURST: begin
          if (beat_fire && beat == 3'd7) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (beat_fire) begin
        beat <= beat + 3'd1;
        if (burst_read) begin
          dq_out          <= mem[ram_idx];
          read_beat_valid <= 1'b1;
          dq_oe           <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr3_command_responder.sv
// Directed bench for ddr3_command_responder: ck is 4 clk long, strobes come from the bench.
`timescale 1ns/1ps
module tb_ddr3_command_responder;

  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;
  localparam int CWL = 5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clk_slow_posedge = 1'b0;
  logic        clk180_slow_posedge = 1'b0;
  logic        reset_n = 1'b1;
  logic        ck_en = 1'b1;
  logic        cs_n = 1'b1;
  logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0]  bank_address = '0;
  logic [13:0] address = '0;
  logic [15:0] dq_in = '0;
  logic [1:0]  dm = '0;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        read_beat_valid;
  logic [7:0]  open_bank_mask;
  logic [15:0] refresh_count;
  logic        protocol_error;

  int checks = 0;
  int errors = 0;
  int cl = 5;
  logic fast_strobe = 1'b0;
  int phase = 3;

  ddr3_command_responder dut (
    .clk                 (clk),
    .resetn              (resetn),
    .clk_slow_posedge    (clk_slow_posedge),
    .clk180_slow_posedge (clk180_slow_posedge),
    .reset_n             (reset_n),
    .ck_en               (ck_en),
    .cs_n                (cs_n),
    .ras_n               (ras_n),
    .cas_n               (cas_n),
    .we_n                (we_n),
    .bank_address        (bank_address),
    .address             (address),
    .dq_in               (dq_in),
    .dm                  (dm),
    .dq_out              (dq_out),
    .dq_oe               (dq_oe),
    .read_beat_valid     (read_beat_valid),
    .open_bank_mask      (open_bank_mask),
    .refresh_count       (refresh_count),
    .protocol_error      (protocol_error)
  );

  initial forever #5 clk = ~clk;

  // ck edge strobes: rising-edge pulse at phase 0, falling-edge pulse at phase 2.
  initial begin
    forever begin
      @(negedge clk);
      if (fast_strobe) begin
        clk_slow_posedge    = 1'b1;
        clk180_slow_posedge = 1'b0;
      end else begin
        phase = (phase + 1) % 4;
        clk_slow_posedge    = (phase == 0);
        clk180_slow_posedge = (phase == 2);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a command now; it is sampled on the next ck rising edge, then pins return to NOP.
  task automatic issue(input logic [2:0] c, input logic [2:0] ba, input logic [13:0] a);
    {ras_n, cas_n, we_n} = c;
    bank_address = ba;
    address = a;
    cs_n = 1'b0;
    @(posedge clk iff clk_slow_posedge);
    #1;
    {ras_n, cas_n, we_n} = C_NOP;
    cs_n = 1'b1;
  endtask

  task automatic write_burst(input logic [2:0] ba, input logic [13:0] a,
                             input logic [7:0][15:0] d, input logic [1:0] m);
    issue(C_WR, ba, a);
    repeat (CWL - 1) @(posedge clk iff clk_slow_posedge);
    #1;
    dq_in = d[0];
    dm = m;
    @(posedge clk iff clk_slow_posedge);
    #1;
    for (int i = 1; i < 8; i++) begin
      dq_in = d[i];
      @(posedge clk iff (clk_slow_posedge || clk180_slow_posedge));
      #1;
    end
    dm = 2'b00;
  endtask

  // Called right after the READ-sampling edge (or a later edge); edges = ck edges until beat 0.
  task automatic expect_read(input string tag, input int edges, input logic [7:0][15:0] d);
    repeat (edges - 1) @(posedge clk iff clk_slow_posedge);
    #1;
    check({tag, " early valid"}, 32'(read_beat_valid), 32'd0);
    check({tag, " early oe"}, 32'(dq_oe), 32'd0);
    @(posedge clk iff clk_slow_posedge);
    #1;
    check({tag, " oe rise"}, 32'(dq_oe), 32'd1);
    for (int b = 0; b < 8; b++) begin
      if (b > 0) begin
        @(posedge clk iff (clk_slow_posedge || clk180_slow_posedge));
        #1;
      end
      check($sformatf("%s beat%0d valid", tag, b), 32'(read_beat_valid), 32'd1);
      check($sformatf("%s beat%0d data", tag, b), 32'(dq_out), 32'(d[b]));
    end
    check({tag, " oe after beat7"}, 32'(dq_oe), 32'd1);
    @(posedge clk iff clk_slow_posedge);
    #1;
    check({tag, " oe fall"}, 32'(dq_oe), 32'd0);
  endtask

  function automatic logic [7:0][15:0] ramp();
    logic [7:0][15:0] r;
    for (int i = 0; i < 8; i++) r[i] = 16'(i + 1);
    return r;
  endfunction

  function automatic logic [7:0][15:0] fill(input logic [15:0] v);
    logic [7:0][15:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst dq_out", 32'(dq_out), 32'd0);
    check("rst dq_oe", 32'(dq_oe), 32'd0);
    check("rst valid", 32'(read_beat_valid), 32'd0);
    check("rst mask", 32'(open_bank_mask), 32'd0);
    check("rst refresh", 32'(refresh_count), 32'd0);
    check("rst error", 32'(protocol_error), 32'd0);
    resetn = 1'b1;
    @(posedge clk iff clk_slow_posedge);
    #1;

    // Write ramp, close and reopen the row, read back at default CL
    issue(C_ACT, 3'd0, 14'd5);
    check("act b0 mask", 32'(open_bank_mask), 32'h01);
    write_burst(3'd0, 14'd0, ramp(), 2'b00);
    issue(C_PRE, 3'd0, 14'd0);
    check("pre b0 mask", 32'(open_bank_mask), 32'h00);
    issue(C_ACT, 3'd0, 14'd5);
    check("reopen b0 mask", 32'(open_bank_mask), 32'h01);
    issue(C_RD, 3'd0, 14'd0);
    expect_read("rd cl5", 5, ramp());

    // READ issued before MRS keeps CL 5; MRS to another bank is ignored; later READ uses CL 7
    issue(C_RD, 3'd0, 14'd0);
    issue(C_MRS, 3'd0, 14'h0030);
    expect_read("rd before mrs", 4, ramp());
    cl = 7;
    issue(C_MRS, 3'd1, 14'h0000);
    issue(C_RD, 3'd0, 14'd0);
    expect_read("rd cl7", cl, ramp());

    // Byte masking: FFFF burst, then 0000 with upper byte masked
    issue(C_ACT, 3'd1, 14'd2);
    check("act b1 mask", 32'(open_bank_mask), 32'h03);
    write_burst(3'd1, 14'h0008, fill(16'hFFFF), 2'b00);
    write_burst(3'd1, 14'h0008, fill(16'h0000), 2'b10);
    issue(C_RD, 3'd1, 14'h0008);
    expect_read("rd masked", cl, fill(16'hFF00));

    // Precharge all, then refresh wrap with every bank closed
    issue(C_PRE, 3'd0, 14'h0400);
    check("pre all mask", 32'(open_bank_mask), 32'h00);
    {ras_n, cas_n, we_n} = C_REF;
    fast_strobe = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    check("refresh ffff", 32'(refresh_count), 32'hFFFF);
    @(posedge clk);
    #1;
    check("refresh wrap", 32'(refresh_count), 32'h0000);
    check("refresh no error", 32'(protocol_error), 32'd0);
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
    fast_strobe = 1'b0;
    @(posedge clk iff clk_slow_posedge);
    #1;

    // READ to a closed bank: error, no burst
    issue(C_RD, 3'd2, 14'd0);
    check("closed rd error", 32'(protocol_error), 32'd1);
    repeat (cl) @(posedge clk iff clk_slow_posedge);
    #1;
    check("closed rd oe", 32'(dq_oe), 32'd0);
    check("closed rd valid", 32'(read_beat_valid), 32'd0);

    // Asynchronous reset during read beat 3
    issue(C_ACT, 3'd0, 14'd5);
    issue(C_RD, 3'd0, 14'd0);
    repeat (cl) @(posedge clk iff clk_slow_posedge);
    repeat (3) @(posedge clk iff (clk_slow_posedge || clk180_slow_posedge));
    #1;
    check("beat3 oe", 32'(dq_oe), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("async rst oe", 32'(dq_oe), 32'd0);
    check("async rst mask", 32'(open_bank_mask), 32'h00);
    check("async rst error", 32'(protocol_error), 32'd0);
    #3;
    resetn = 1'b1;
    cl = 5;
    @(posedge clk iff clk_slow_posedge);
    #1;

    // Data survives reset; WRITE during WAIT_LAT is flagged and dropped
    issue(C_ACT, 3'd0, 14'd5);
    issue(C_RD, 3'd0, 14'd0);
    issue(C_WR, 3'd0, 14'd0);
    check("wr in wait_lat error", 32'(protocol_error), 32'd1);
    expect_read("rd after reset", cl - 1, ramp());

    // DDR reset pin clears state synchronously
    issue(C_ACT, 3'd3, 14'd0);
    check("act b3 mask", 32'(open_bank_mask), 32'h09);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_n mask", 32'(open_bank_mask), 32'h00);
    check("reset_n error", 32'(protocol_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
